baud_rate: RTL and testbench

Free-running baud-rate tick generator for the UART blocks. Divides the system clock down to single-cycle strobes at the configured baud rate (`baud_tick`) and at an oversampled rate (`os_tick`) for receiver sampling. Sits between the system clock/reset and the UART TX/RX state machines, which advance one bit per `baud_tick`.

---
 rtl/baud_rate.sv | 96 +++++++++
 tb/tb_baud_rate.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/baud_rate.sv
// baud_rate: free-running baud_tick / os_tick strobe generator feeding the UART TX/RX FSMs.
// Integer dividers by default; define BAUDRATE_FRAC_EN for phase-accumulator dividers.
module baud_rate #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic baud_tick,
  output logic os_tick
);

  localparam longint OS_RATE = longint'(BAUD) * longint'(OVERSAMPLE);

  // Below this ratio the oversample divider collapses to 1 and os_tick would stick high.
  if (longint'(CLK_FREQ) < 2 * OS_RATE) begin : g_cfg_check
    $error("baud_rate: CLK_FREQ must be at least 2*BAUD*OVERSAMPLE");
  end

  logic baud_tick_q, baud_tick_d;
  logic os_tick_q, os_tick_d;

`ifdef BAUDRATE_FRAC_EN
  localparam int AW = $clog2(longint'(CLK_FREQ) + OS_RATE);
  localparam logic [AW:0] FREQ_W   = (AW+1)'(CLK_FREQ);
  localparam logic [AW:0] BAUD_INC = (AW+1)'(BAUD);
  localparam logic [AW:0] OS_INC   = (AW+1)'(OS_RATE);

  logic [AW-1:0] baud_acc_q, baud_acc_d;
  logic [AW-1:0] os_acc_q, os_acc_d;
  logic [AW:0]   baud_sum, os_sum;

  // Accumulators wrap modulo CLK_FREQ, so exactly BAUD ticks land in every CLK_FREQ cycles.
  always_comb begin
    baud_sum    = {1'b0, baud_acc_q} + BAUD_INC;
    os_sum      = {1'b0, os_acc_q} + OS_INC;
    baud_tick_d = (baud_sum >= FREQ_W);
    os_tick_d   = (os_sum >= FREQ_W);
    baud_acc_d  = baud_tick_d ? AW'(baud_sum - FREQ_W) : baud_sum[AW-1:0];
    os_acc_d    = os_tick_d ? AW'(os_sum - FREQ_W) : os_sum[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_acc_q <= '0;
      os_acc_q   <= '0;
    end else begin
      baud_acc_q <= baud_acc_d;
      os_acc_q   <= os_acc_d;
    end
  end
`else
  localparam longint DIV    = (longint'(CLK_FREQ) + longint'(BAUD) / 2) / longint'(BAUD);
  localparam longint OS_DIV = (longint'(CLK_FREQ) + OS_RATE / 2) / OS_RATE;
  localparam int     BW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int     OW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OS_DIV - 1);

  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic [OW-1:0] os_cnt_q, os_cnt_d;

  always_comb begin
    baud_tick_d = (baud_cnt_q == BAUD_LAST);
    os_tick_d   = (os_cnt_q == OS_LAST);
    baud_cnt_d  = baud_tick_d ? '0 : baud_cnt_q + BW'(1);
    os_cnt_d    = os_tick_d ? '0 : os_cnt_q + OW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt_q <= '0;
      os_cnt_q   <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      os_cnt_q   <= os_cnt_d;
    end
  end
`endif

  // Ticks are registered: high for the cycle after the divider's terminal edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_tick_q <= 1'b0;
      os_tick_q   <= 1'b0;
    end else begin
      baud_tick_q <= baud_tick_d;
      os_tick_q   <= os_tick_d;
    end
  end

  assign baud_tick = baud_tick_q;
  assign os_tick   = os_tick_q;

endmodule

// File: tb/tb_baud_rate.sv
// Self-checking bench for baud_rate: default and BAUD=115200 instances on a 100 MHz clock.
module tb_baud_rate;

  localparam longint CF        = 100_000_000;
  localparam longint B_DEF     = 9600;
  localparam longint B_FAST    = 115200;
  localparam longint OSR       = 16;
  localparam longint FIRST_DEF = 10417;

  logic   clk, rst;
  logic   d_baud, d_os, f_baud, f_os;
  longint edges;
  int     errors, checks;

  baud_rate u_def (.clk(clk), .rst(rst), .baud_tick(d_baud), .os_tick(d_os));
  baud_rate #(.CLK_FREQ(100_000_000), .BAUD(115200), .OVERSAMPLE(16))
    u_fast (.clk(clk), .rst(rst), .baud_tick(f_baud), .os_tick(f_os));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising edges seen since the last reset release.
  always @(posedge clk or negedge rst)
    if (!rst) edges <= 0;
    else      edges <= edges + 1;

  // Expected tick level in the cycle following the k-th edge after release.
  function automatic bit exp_tick(longint k, longint rate);
    if (k <= 0) return 1'b0;
`ifdef BAUDRATE_FRAC_EN
    return ((k * rate) / CF) != (((k - 1) * rate) / CF);
`else
    return (k % ((CF + rate / 2) / rate)) == 0;
`endif
  endfunction

  function automatic longint exp_count(longint n, longint rate);
`ifdef BAUDRATE_FRAC_EN
    return (n * rate) / CF;
`else
    return n / ((CF + rate / 2) / rate);
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      checks++;
      if ({d_baud, d_os, f_baud, f_os} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold: cycle %0d outputs=%b required 0000", i, {d_baud, d_os, f_baud, f_os});
      end
    end
  endtask

  task automatic test_release();
    longint nb = 0, no = 0, first = -1;
    @(posedge clk);
    #3 rst = 1'b1;
    for (int i = 0; i < 20850; i++) begin
      @(negedge clk);
      checks += 4;
      if (d_baud !== exp_tick(edges, B_DEF)) begin
        errors++; $display("FAIL release_d_baud: edge %0d got %b required %b", edges, d_baud, exp_tick(edges, B_DEF));
      end
      if (d_os !== exp_tick(edges, B_DEF * OSR)) begin
        errors++; $display("FAIL release_d_os: edge %0d got %b required %b", edges, d_os, exp_tick(edges, B_DEF * OSR));
      end
      if (f_baud !== exp_tick(edges, B_FAST)) begin
        errors++; $display("FAIL release_f_baud: edge %0d got %b required %b", edges, f_baud, exp_tick(edges, B_FAST));
      end
      if (f_os !== exp_tick(edges, B_FAST * OSR)) begin
        errors++; $display("FAIL release_f_os: edge %0d got %b required %b", edges, f_os, exp_tick(edges, B_FAST * OSR));
      end
      if (d_baud === 1'b1) begin
        nb++;
        if (first < 0) first = edges;
      end
      if (d_os === 1'b1) no++;
    end
    checks += 3;
    if (first !== FIRST_DEF) begin
      errors++; $display("FAIL first_baud_edge: got %0d required %0d", first, FIRST_DEF);
    end
    if (nb !== exp_count(edges, B_DEF)) begin
      errors++; $display("FAIL baud_count: got %0d required %0d", nb, exp_count(edges, B_DEF));
    end
    if (no !== exp_count(edges, B_DEF * OSR)) begin
      errors++; $display("FAIL os_count: got %0d required %0d", no, exp_count(edges, B_DEF * OSR));
    end
  endtask

  task automatic test_async_reset();
    bit     seen = 1'b0;
    longint first = -1;
    repeat ($urandom_range(3000, 6000)) @(negedge clk);
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (d_os === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL async_wait_os: no os_tick within 2000 cycles");
    end
    #($urandom_range(1, 3)) rst = 1'b0;
    #1;
    checks++;
    if ({d_baud, d_os, f_baud, f_os} !== 4'b0000) begin
      errors++; $display("FAIL async_drop: outputs=%b required 0000", {d_baud, d_os, f_baud, f_os});
    end
    #19 rst = 1'b1;
    for (int i = 0; i < FIRST_DEF + 20; i++) begin
      @(negedge clk);
      checks += 4;
      if (d_baud !== exp_tick(edges, B_DEF)) begin
        errors++; $display("FAIL rerelease_d_baud: edge %0d got %b required %b", edges, d_baud, exp_tick(edges, B_DEF));
      end
      if (d_os !== exp_tick(edges, B_DEF * OSR)) begin
        errors++; $display("FAIL rerelease_d_os: edge %0d got %b required %b", edges, d_os, exp_tick(edges, B_DEF * OSR));
      end
      if (f_baud !== exp_tick(edges, B_FAST)) begin
        errors++; $display("FAIL rerelease_f_baud: edge %0d got %b required %b", edges, f_baud, exp_tick(edges, B_FAST));
      end
      if (f_os !== exp_tick(edges, B_FAST * OSR)) begin
        errors++; $display("FAIL rerelease_f_os: edge %0d got %b required %b", edges, f_os, exp_tick(edges, B_FAST * OSR));
      end
      if (d_baud === 1'b1 && first < 0) first = edges;
    end
    checks++;
    if (first !== FIRST_DEF) begin
      errors++; $display("FAIL rerelease_first_baud: got edge %0d required %0d", first, FIRST_DEF);
    end
  endtask

  task automatic test_random_resets();
    for (int it = 0; it < 5; it++) begin
      @(negedge clk);
      #($urandom_range(1, 4)) rst = 1'b0;
      #1;
      checks++;
      if ({d_baud, d_os, f_baud, f_os} !== 4'b0000) begin
        errors++; $display("FAIL rand_drop: iter %0d outputs=%b required 0000", it, {d_baud, d_os, f_baud, f_os});
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      #($urandom_range(1, 4)) rst = 1'b1;
      repeat ($urandom_range(300, 3000)) begin
        @(negedge clk);
        checks += 3;
        if (d_os !== exp_tick(edges, B_DEF * OSR)) begin
          errors++; $display("FAIL rand_d_os: edge %0d got %b required %b", edges, d_os, exp_tick(edges, B_DEF * OSR));
        end
        if (f_baud !== exp_tick(edges, B_FAST)) begin
          errors++; $display("FAIL rand_f_baud: edge %0d got %b required %b", edges, f_baud, exp_tick(edges, B_FAST));
        end
        if (f_os !== exp_tick(edges, B_FAST * OSR)) begin
          errors++; $display("FAIL rand_f_os: edge %0d got %b required %b", edges, f_os, exp_tick(edges, B_FAST * OSR));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] cur, prev;
    longint     last[4];
    longint     rate[4];
    longint     sp, nom;
    rate = '{B_DEF, B_DEF * OSR, B_FAST, B_FAST * OSR};
    last = '{-1, -1, -1, -1};
    prev = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cur = {f_os, f_baud, d_os, d_baud};
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (cur[j] === 1'b1 && prev[j] === 1'b1) begin
          errors++; $display("FAIL b2b_width[%0d]: high on consecutive cycles at edge %0d", j, edges);
        end
        if (cur[j] === 1'b1) begin
          if (last[j] >= 0) begin
            sp = edges - last[j];
            checks++;
`ifdef BAUDRATE_FRAC_EN
            nom = CF / rate[j];
            if (sp != nom && sp != nom + 1) begin
              errors++; $display("FAIL b2b_spacing[%0d]: got %0d required %0d or %0d", j, sp, nom, nom + 1);
            end
`else
            nom = (CF + rate[j] / 2) / rate[j];
            if (sp != nom) begin
              errors++; $display("FAIL b2b_spacing[%0d]: got %0d required %0d", j, sp, nom);
            end
`endif
          end
          last[j] = edges;
        end
      end
      prev = cur;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_release();
    test_async_reset();
    test_random_resets();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
